// File: rtl/clk_div_pkg.sv
// Shared types and constants for the runtime-programmable clock-enable divider bank.
// Optional global restart is built when CLKDIV_SYNC_EN is defined.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        DONE = 2'd2
    } cfg_state_t;

    localparam int NCH_DEF   = 4;
    localparam int DIV_W_DEF = 24;

    // Half-period dividers for a 100 MHz system clock
    localparam int DIV_20HZ   = 2500000;
    localparam int DIV_240HZ  = 208333;
    localparam int DIV_9600HZ = 5208;
    localparam int DIV_6M25   = 8;

endpackage

// File: rtl/clk_div_scheduler_if.sv
// Single-port configuration channel of the divider bank.
// master drives requests, slave is the scheduler.
interface clk_div_scheduler_if #(
    parameter int CH_W  = 2,
    parameter int DIV_W = 24
) ();
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_en;
    logic             cfg_done;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_en,
        input  cfg_ready, cfg_done, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_en,
        output cfg_ready, cfg_done, cfg_err
    );
endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, toggling output and toggle strobe.
// New div/en are applied only on the commit strobe; restart input exists when CLKDIV_SYNC_EN is defined.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             commit,
    input  logic [DIV_W-1:0] new_div,
    input  logic             new_en,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync,
`endif
    output logic             clk_o,
    output logic             tick_o,
    output logic             term,
    output logic             fall_term,
    output logic             en
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;

    // en is never set with div==0, so div-1 cannot wrap while counting
    assign term      = en && (cnt == (div - 1'b1));
    assign fall_term = term && clk_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            div    <= '0;
            en     <= 1'b0;
            clk_o  <= 1'b0;
            tick_o <= 1'b0;
        end else begin
            tick_o <= 1'b0;
`ifdef CLKDIV_SYNC_EN
            if (sync) begin
                cnt   <= '0;
                clk_o <= 1'b0;
                if (commit) begin
                    en  <= new_en;
                    div <= new_div;
                end
            end else
`endif
            if (commit) begin
                en  <= new_en;
                div <= new_div;
                cnt <= '0;
                if (term) begin
                    clk_o  <= ~clk_o;
                    tick_o <= 1'b1;
                end
            end else if (term) begin
                cnt    <= '0;
                clk_o  <= ~clk_o;
                tick_o <= 1'b1;
            end else if (en) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_scheduler.sv
// Bank of NCH programmable square-wave dividers with a glitch-free config FSM.
// Defining CLKDIV_SYNC_EN adds the sync_i global restart input.
//
//  state | meaning
//  IDLE  | ready for a request; invalid requests pulse cfg_err
//  PEND  | shadow holds a request, waiting for the target's safe boundary
//  DONE  | commit happened; cfg_done pulses for one cycle
module clk_div_scheduler
    import clk_div_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int DIV_W = DIV_W_DEF,
    parameter int CH_W  = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    clk_div_scheduler_if.slave cfg,
`ifdef CLKDIV_SYNC_EN
    input  logic            sync_i,
`endif
    output logic [NCH-1:0]  clk_o,
    output logic [NCH-1:0]  tick_o
);

    cfg_state_t       state, state_nxt;
    logic [CH_W-1:0]  sh_ch;
    logic [DIV_W-1:0] sh_div;
    logic             sh_en;
    logic [NCH-1:0]   term, fall_term, ch_en, commit;
    logic             accept, req_bad, commit_ok;

    assign accept  = (state == IDLE) && cfg.cfg_valid;
    assign req_bad = (cfg.cfg_en && (cfg.cfg_div == '0)) || (32'(cfg.cfg_ch) >= NCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        cfg.cfg_ready = 1'b0;
        cfg.cfg_done  = 1'b0;
        commit        = '0;
        // Disabled target commits at once; enable waits for any toggle, disable for the falling one
        if (!ch_en[sh_ch])  commit_ok = 1'b1;
        else if (sh_en)     commit_ok = term[sh_ch];
        else                commit_ok = fall_term[sh_ch];
`ifdef CLKDIV_SYNC_EN
        if (sync_i) commit_ok = 1'b1;
`endif
        case (state)
            IDLE: begin
                cfg.cfg_ready = 1'b1;
                if (cfg.cfg_valid && !req_bad) state_nxt = PEND;
            end
            PEND: begin
                if (commit_ok) begin
                    commit[sh_ch] = 1'b1;
                    state_nxt     = DONE;
                end
            end
            DONE: begin
                cfg.cfg_done = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_ch       <= '0;
            sh_div      <= '0;
            sh_en       <= 1'b0;
            cfg.cfg_err <= 1'b0;
        end else begin
            cfg.cfg_err <= accept && req_bad;
            if (accept && !req_bad) begin
                sh_ch  <= cfg.cfg_ch;
                sh_div <= cfg.cfg_div;
                sh_en  <= cfg.cfg_en;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        clk_div_channel #(.DIV_W(DIV_W)) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .commit    (commit[i]),
            .new_div   (sh_div),
            .new_en    (sh_en),
`ifdef CLKDIV_SYNC_EN
            .sync      (sync_i),
`endif
            .clk_o     (clk_o[i]),
            .tick_o    (tick_o[i]),
            .term      (term[i]),
            .fall_term (fall_term[i]),
            .en        (ch_en[i])
        );
    end

endmodule

// File: tb/tb_clk_div_scheduler.sv
// Scoreboard bench for clk_div_scheduler: expected cfg events and per-channel ticks are queued
// by the stimulus and consumed by a negedge monitor. Restart test runs when CLKDIV_SYNC_EN is defined.
module tb_clk_div_scheduler;
    import clk_div_pkg::*;

    localparam int NCH   = 4;
    localparam int DIV_W = 24;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] clk_o, tick_o;
`ifdef CLKDIV_SYNC_EN
    logic           sync_i = 1'b0;
`endif

    clk_div_scheduler_if #(.CH_W(2), .DIV_W(DIV_W)) cfg_if ();

    clk_div_scheduler #(.NCH(NCH), .DIV_W(DIV_W), .CH_W(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cfg    (cfg_if),
`ifdef CLKDIV_SYNC_EN
        .sync_i (sync_i),
`endif
        .clk_o  (clk_o),
        .tick_o (tick_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit is_err; int cyc; } ev_t;
    typedef struct { int cyc; bit lvl; } tk_t;
    ev_t ev_q[$];
    tk_t tq[NCH][$];
    bit  watch[NCH];
    int  checks = 0;
    int  failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input bit is_err, input int c);
        ev_t e;
        e.is_err = is_err;
        e.cyc    = c;
        ev_q.push_back(e);
    endtask

    task automatic push_tk(input int ch, input int c, input bit lvl);
        tk_t t;
        t.cyc = c;
        t.lvl = lvl;
        tq[ch].push_back(t);
    endtask

    // Called right after a posedge (+1); advances to the given cycle
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_cfg(input int ch, input int dv, input bit en, output int hs);
        check("cfg_ready_at_issue", int'(cfg_if.cfg_ready), 1);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 2'(ch);
        cfg_if.cfg_div   = DIV_W'(dv);
        cfg_if.cfg_en    = en;
        hs = cyc;
        @(posedge clk);
        #1;
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic wait_ev();
        int n = 0;
        while (ev_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (ev_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL cfg_event_timeout: %0d events pending, required 0", ev_q.size());
            ev_q.delete();
        end
    endtask

    task automatic drain(input int ch);
        int n = 0;
        while (tq[ch].size() != 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (tq[ch].size() != 0) begin
            checks++;
            failures++;
            $display("FAIL tick_timeout ch%0d: %0d ticks pending, required 0", ch, tq[ch].size());
            tq[ch].delete();
        end
        watch[ch] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (cfg_if.cfg_done || cfg_if.cfg_err) begin
                if (ev_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_cfg_event: done=%0b err=%0b at cycle %0d, required none",
                             cfg_if.cfg_done, cfg_if.cfg_err, cyc);
                end else begin
                    ev_t e;
                    e = ev_q.pop_front();
                    check("cfg_event_is_err", int'(cfg_if.cfg_err), int'(e.is_err));
                    check("cfg_event_cycle", cyc, e.cyc);
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (watch[i] && tick_o[i]) begin
                    if (tq[i].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_tick ch%0d at cycle %0d, required none", i, cyc);
                    end else begin
                        tk_t t;
                        t = tq[i].pop_front();
                        check($sformatf("tick_cycle_ch%0d", i), cyc, t.cyc);
                        check($sformatf("tick_level_ch%0d", i), int'(clk_o[i]), int'(t.lvl));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0, hs1, hs2, hs3, hs4, hs, h5, h6, t_c, h;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_div   = '0;
        cfg_if.cfg_en    = 1'b0;
        for (int i = 0; i < NCH; i++) watch[i] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_clk_o", int'(clk_o), 0);
        check("rst_tick_o", int'(tick_o), 0);
        check("rst_cfg_ready", int'(cfg_if.cfg_ready), 1);
        check("rst_cfg_done", int'(cfg_if.cfg_done), 0);
        check("rst_cfg_err", int'(cfg_if.cfg_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ch0 enable, div 8: done 2 cycles after handshake, toggles every 8
        do_cfg(0, 8, 1'b1, hs0);
        push_ev(1'b0, hs0 + 2);
        for (int k = 1; k <= 40; k++) push_tk(0, hs0 + 2 + 8 * k, (k % 2) == 1);
        watch[0] = 1'b1;
        wait_ev();

        // Invalid request: err pulse, ready stays high, ch0 keeps its cadence
        do_cfg(0, 0, 1'b1, hs);
        push_ev(1'b1, hs + 1);
        check("ready_after_err", int'(cfg_if.cfg_ready), 1);
        wait_ev();
        do_cfg(3, 0, 1'b0, hs);
        push_ev(1'b0, hs + 2);
        wait_ev();
        check("ch3_stays_low", int'(clk_o[3]), 0);

        // ch1 div 5, reprogrammed to 3 mid-period
        do_cfg(1, 5, 1'b1, hs1);
        push_ev(1'b0, hs1 + 2);
        push_tk(1, hs1 + 7, 1'b1);
        push_tk(1, hs1 + 12, 1'b0);
        push_tk(1, hs1 + 17, 1'b1);
        push_tk(1, hs1 + 20, 1'b0);
        push_tk(1, hs1 + 23, 1'b1);
        push_tk(1, hs1 + 26, 1'b0);
        watch[1] = 1'b1;
        goto(hs1 + 14);
        do_cfg(1, 3, 1'b1, hs2);
        check("reprogram_issue_cycle", hs2, hs1 + 14);
        push_ev(1'b0, hs1 + 17);
        goto(hs1 + 16);
        check("ready_low_pending", int'(cfg_if.cfg_ready), 0);
        wait_ev();
        drain(1);

        // ch2 div 4, disabled: commit only on the falling toggle
        do_cfg(2, 4, 1'b1, hs3);
        push_ev(1'b0, hs3 + 2);
        push_tk(2, hs3 + 6, 1'b1);
        push_tk(2, hs3 + 10, 1'b0);
        push_tk(2, hs3 + 14, 1'b1);
        push_tk(2, hs3 + 18, 1'b0);
        watch[2] = 1'b1;
        goto(hs3 + 11);
        do_cfg(2, 0, 1'b0, hs4);
        push_ev(1'b0, hs3 + 18);
        goto(hs3 + 45);
        check("ch2_held_low", int'(clk_o[2]), 0);
        drain(2);

        // ch0 to div 1000 at its next terminal, then reset while another request is pending
        drain(0);
        do_cfg(0, 1000, 1'b1, h5);
        t_c = hs0 + 9;
        while (t_c < h5 + 1) t_c += 8;
        push_ev(1'b0, t_c + 1);
        wait_ev();
        do_cfg(0, 5, 1'b1, h6);
        goto(h6 + 10);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_clk_o", int'(clk_o), 0);
        check("async_rst_tick_o", int'(tick_o), 0);
        check("async_rst_ready", int'(cfg_if.cfg_ready), 1);
        check("async_rst_done", int'(cfg_if.cfg_done), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NCH; i++) watch[i] = 1'b1;
        h = cyc;
        goto(h + 40);
        check("post_rst_clk_o", int'(clk_o), 0);
        check("post_rst_ready", int'(cfg_if.cfg_ready), 1);
        for (int i = 0; i < NCH; i++) watch[i] = 1'b0;

`ifdef CLKDIV_SYNC_EN
        do_cfg(0, 3, 1'b1, hs);
        push_ev(1'b0, hs + 2);
        wait_ev();
        do_cfg(1, 7, 1'b1, hs);
        push_ev(1'b0, hs + 2);
        wait_ev();
        goto(cyc + 5);
        h = cyc;
        sync_i = 1'b1;
        @(posedge clk);
        #1;
        sync_i = 1'b0;
        check("sync_clk_o_low", int'(clk_o[1:0]), 0);
        check("sync_no_tick", int'(tick_o[1:0]), 0);
        push_tk(0, h + 4, 1'b1);
        push_tk(0, h + 7, 1'b0);
        push_tk(0, h + 10, 1'b1);
        push_tk(1, h + 8, 1'b1);
        watch[0] = 1'b1;
        watch[1] = 1'b1;
        drain(0);
        drain(1);
`endif

        check("ev_queue_empty", ev_q.size(), 0);
        for (int i = 0; i < NCH; i++) check($sformatf("tick_queue_empty_ch%0d", i), tq[i].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
